// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage sequencer for push/pop/ldd/std
module mem_stage_ctrl #(
    parameter int                ADDR_W  = 20,
    parameter int                DATA_W  = 16,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}},
    parameter int                TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [8:0]        ctrl_in,
    input  logic [ADDR_W-1:0] ea_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rdata_out,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] sp_out
);
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_sp;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_is_push;
    logic              r_is_pop;

    logic [3:0] w_ops;
    logic       w_pop, w_push, w_std, w_ldd;
    logic       w_noop, w_multi, w_ovf, w_unf, w_reject, w_timeout;
    logic       w_unused_ctrl;

    assign w_ops                        = ctrl_in[6:3];
    assign {w_pop, w_push, w_std, w_ldd} = w_ops;
    assign w_unused_ctrl                = ^{ctrl_in[8:7], ctrl_in[2:0]};
    assign w_noop    = (w_ops == 4'b0000);
    // Clearing the lowest set bit leaves something only when two or more ops are set.
    assign w_multi   = |(w_ops & (w_ops - 4'd1));
    assign w_ovf     = w_push && (r_sp == '0);
    assign w_unf     = w_pop && (r_sp == SP_INIT);
    assign w_reject  = w_multi || w_ovf || w_unf;
    assign w_timeout = (r_cnt == CNT_LAST);

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rdata_out = r_rdata;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign sp_out    = r_sp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = (w_reject || w_noop) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ack || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp        <= SP_INIT;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_is_push   <= 1'b0;
            r_is_pop    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (req_valid) begin
                        r_err <= w_reject;
                        if (!w_reject && !w_noop) begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= w_push || w_std;
                            r_mem_addr  <= w_push ? r_sp :
                                           w_pop  ? r_sp + ADDR_W'(1) : ea_in;
                            r_mem_wdata <= wdata_in;
                            r_is_push   <= w_push;
                            r_is_pop    <= w_pop;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack in the final counted cycle still completes the access.
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b0;
                        r_cnt     <= '0;
                        if (!r_mem_we) begin
                            r_rdata <= mem_rdata;
                        end
                        if (r_is_push) begin
                            r_sp <= r_sp - ADDR_W'(1);
                        end else if (r_is_pop) begin
                            r_sp <= r_sp + ADDR_W'(1);
                        end
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - scoreboard bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  ctrl_in;
    logic [19:0] ea_in;
    logic [15:0] wdata_in;
    logic        rsp_valid;
    logic [15:0] rdata_out;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [19:0] sp_out;

    mem_stage_ctrl #(
        .ADDR_W (20),
        .DATA_W (16),
        .SP_INIT(20'hFFFFF),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .ctrl_in  (ctrl_in),
        .ea_in    (ea_in),
        .wdata_in (wdata_in),
        .rsp_valid(rsp_valid),
        .rdata_out(rdata_out),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .sp_out   (sp_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        logic [19:0] sp;
    } rsp_t;

    rsp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic done     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    initial begin
        rsp_t e;
        while (!done) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 && rst_n === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp err", 32'(err), 32'(e.err));
                    check("rsp rdata_out", 32'(rdata_out), 32'(e.rdata));
                    check("rsp sp_out", 32'(sp_out), 32'(e.sp));
                end
            end
        end
    end

    // delay: cycles of wait before ack; negative means never ack.
    task automatic issue(input string name, input logic [8:0] c, input logic [19:0] ea,
                         input logic [15:0] wd, input int delay, input logic [15:0] mrd,
                         input logic exp_mem, input logic [19:0] exp_addr, input logic exp_we,
                         input logic exp_err, input logic [15:0] exp_rd, input logic [19:0] exp_sp);
        int   n;
        rsp_t e;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " req_ready"}, 32'(req_ready), 32'd1);
        e.err = exp_err; e.rdata = exp_rd; e.sp = exp_sp;
        sb_q.push_back(e);
        ctrl_in = c; ea_in = ea; wdata_in = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!exp_mem) begin
            check({name, " no mem_req"}, 32'(mem_req), 32'd0);
            check({name, " rsp at T+1"}, 32'(rsp_valid), 32'd1);
        end else begin
            check({name, " mem_req"}, 32'(mem_req), 32'd1);
            check({name, " mem_addr"}, 32'(mem_addr), 32'(exp_addr));
            check({name, " mem_we"}, 32'(mem_we), 32'(exp_we));
            if (exp_we) check({name, " mem_wdata"}, 32'(mem_wdata), 32'(wd));
            if (delay < 0) begin
                n = 0;
                while (mem_req === 1'b1 && n < 40) begin
                    n++;
                    @(posedge clk); #1;
                end
                check({name, " mem_req cycles"}, 32'(n), 32'(TIMEOUT));
                check({name, " rsp after timeout"}, 32'(rsp_valid), 32'd1);
            end else begin
                for (int i = 0; i < delay; i++) begin
                    check({name, " mem_req held"}, 32'(mem_req), 32'd1);
                    check({name, " addr held"}, 32'(mem_addr), 32'(exp_addr));
                    @(posedge clk); #1;
                end
                check({name, " mem_req at ack"}, 32'(mem_req), 32'd1);
                mem_ack = 1'b1; mem_rdata = mrd;
                @(posedge clk); #1;
                mem_ack = 1'b0; mem_rdata = 16'h0;
                check({name, " rsp latency"}, 32'(rsp_valid), 32'd1);
                check({name, " mem_req dropped"}, 32'(mem_req), 32'd0);
            end
        end
        @(posedge clk); #1;
        check({name, " rsp one cycle"}, 32'(rsp_valid), 32'd0);
        check({name, " ready after rsp"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; ctrl_in = '0; ea_in = '0; wdata_in = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset sp_out", 32'(sp_out), 32'hFFFFF);
        check("reset rdata_out", 32'(rdata_out), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //     name        ctrl     ea        wdata    dly mrd      mem  addr      we   err  rdata    sp
        issue("push",      9'h020, 20'h0,    16'hBEEF, 0, 16'h0,    1, 20'hFFFFF, 1, 0, 16'h0000, 20'hFFFFE);
        issue("pop",       9'h040, 20'h0,    16'h0,    3, 16'hBEEF, 1, 20'hFFFFF, 0, 0, 16'hBEEF, 20'hFFFFF);
        issue("pop empty", 9'h040, 20'h0,    16'h0,    0, 16'h0,    0, 20'h0,     0, 1, 16'hBEEF, 20'hFFFFF);
        issue("std",       9'h010, 20'h00123, 16'h1234, 1, 16'h0,   1, 20'h00123, 1, 0, 16'hBEEF, 20'hFFFFF);
        issue("ldd",       9'h008, 20'h00123, 16'h0,   2, 16'h1234, 1, 20'h00123, 0, 0, 16'h1234, 20'hFFFFF);
        issue("ldd tmo",   9'h008, 20'h00456, 16'h0,  -1, 16'h0,    1, 20'h00456, 0, 1, 16'h1234, 20'hFFFFF);
        issue("multi op",  9'h060, 20'h0,    16'h5555, 0, 16'h0,    0, 20'h0,     0, 1, 16'h1234, 20'hFFFFF);
        issue("noop",      9'h187, 20'h0,    16'h0,    0, 16'h0,    0, 20'h0,     0, 0, 16'h1234, 20'hFFFFF);
        issue("push edge", 9'h020, 20'h0,    16'hA5A5, 14, 16'h0,   1, 20'hFFFFF, 1, 0, 16'h1234, 20'hFFFFE);

        // Reset in the middle of an access: mem_req drops at once, a late ack is ignored.
        ctrl_in = 9'h008; ea_in = 20'h00777; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst-mid mem_req before", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst-mid mem_req async", 32'(mem_req), 32'd0);
        check("rst-mid sp_out", 32'(sp_out), 32'hFFFFF);
        check("rst-mid req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 16'h0;
        check("late ack rsp_valid", 32'(rsp_valid), 32'd0);
        check("late ack rdata_out", 32'(rdata_out), 32'd0);
        check("late ack mem_req", 32'(mem_req), 32'd0);
        issue("pop post-rst", 9'h040, 20'h0, 16'h0, 0, 16'h0, 0, 20'h0, 0, 1, 16'h0000, 20'hFFFFF);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
